// File: rtl/float_div_scheduler.sv
// Round-robin front end that shares one combinational single-precision divider
// among NREQ requesters, with one operation in flight at a time.

module FloatingDivision (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);
  logic              w_sign;
  logic [7:0]        w_ea, w_eb;
  logic [23:0]       w_ma, w_mb, w_mant;
  logic [25:0]       w_q;
  logic [24:0]       w_mr;
  logic signed [9:0] w_exp;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_nan;

  always_comb begin
    w_sign   = A[31] ^ B[31];
    w_ea     = A[30:23];
    w_eb     = B[30:23];
    w_ma     = {1'b1, A[22:0]};
    w_mb     = {1'b1, B[22:0]};
    // Denormal operands are flushed to zero.
    w_a_zero = (w_ea == 8'd0);
    w_b_zero = (w_eb == 8'd0);
    w_a_inf  = (w_ea == 8'hFF) && (A[22:0] == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (B[22:0] == 23'd0);
    w_nan    = ((w_ea == 8'hFF) && (A[22:0] != 23'd0)) ||
               ((w_eb == 8'hFF) && (B[22:0] != 23'd0)) ||
               (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    // Significand ratio scaled by 2^25 lies strictly between 2^24 and 2^26.
    w_q      = 26'({w_ma, 25'd0} / {25'd0, w_mb});
    w_mant   = '0;
    w_mr     = '0;
    w_exp    = '0;
    if (w_q[25]) begin
      w_mant = w_q[25:2];
      w_mr   = {1'b0, w_mant} + {24'd0, w_q[1]};
      w_exp  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
    end else begin
      w_mant = w_q[24:1];
      w_mr   = {1'b0, w_mant} + {24'd0, w_q[0]};
      w_exp  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd126;
    end
    if (w_mr[24]) w_exp = w_exp + 10'sd1;
    if (w_nan)                       result = 32'h7FC0_0000;
    else if (w_a_inf || w_b_zero)    result = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_inf)    result = {w_sign, 31'd0};
    else if (w_exp >= 10'sd255)      result = {w_sign, 8'hFF, 23'd0};
    else if (w_exp <= 10'sd0)        result = {w_sign, 31'd0};
    else result = {w_sign, w_exp[7:0], (w_mr[24] ? w_mr[23:1] : w_mr[22:0])};
  end
endmodule

module float_div_scheduler #(
  parameter int NREQ       = 4,
  parameter int DIV_CYCLES = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_dz,
  output logic [1:0]           o_dbg_state
);
  // Handshakes: req i transfers on an edge with req_valid[i] & req_ready[i];
  // the response transfers on an edge with rsp_valid & rsp_ready.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t         r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_grant;
  logic [3:0]     r_cnt;
  logic [31:0]    r_op_a, r_op_b, r_data, w_div_q;
  logic           r_dz, w_found, w_hs;
  int             w_idx;

  FloatingDivision u_div (
    .A      (r_op_a),
    .B      (r_op_b),
    .result (w_div_q)
  );

  // Walk downwards so the requester closest to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_ptr;
    w_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = IDW'(w_idx);
      end
    end
  end

  assign w_hs = (r_state == S_IDLE) && w_found;

  always_comb begin
    req_ready = '0;
    if (w_hs && rst_n) req_ready[w_grant] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_HOLD;
      S_HOLD:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_id   <= '0;
      r_data <= '0;
      r_dz   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_op_a <= req_a[32*int'(w_grant) +: 32];
        r_op_b <= req_b[32*int'(w_grant) +: 32];
        r_id   <= w_grant;
        r_ptr  <= (int'(w_grant) == NREQ - 1) ? '0 : w_grant + IDW'(1);
        r_cnt  <= 4'(DIV_CYCLES - 1);
      end
      if (r_state == S_WAIT) begin
        if (r_cnt == 4'd0) begin
          r_data <= w_div_q;
          r_dz   <= (r_op_b[30:0] == 31'd0);
        end else begin
          r_cnt  <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign rsp_valid   = (r_state == S_HOLD);
  assign rsp_data    = r_data;
  assign rsp_id      = r_id;
  assign rsp_dz      = r_dz;
  assign o_dbg_state = r_state;
endmodule

// File: doc/float_div_scheduler.md
FLOAT_DIV_SCHEDULER -- requirements
Module: float_div_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the divider; legal range 2..8.
REQ-002 Parameter DIV_CYCLES, default 2, settle cycles allowed for the combinational divider path; legal range 1..15.
REQ-003 Parameter IDW, default $clog2(NREQ), width of the requester ID.
REQ-004 One clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NREQ  per-requester operation request; bit i belongs to requester i.
REQ-008 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-009 req_a  input  NREQ*32  IEEE-754 single dividends; requester i at bits [32*i+31:32*i].
REQ-010 req_b  input  NREQ*32  IEEE-754 single divisors, same packing as req_a.
REQ-011 rsp_valid  output  1  quotient available.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_data  output  32  quotient A/B from the internal FloatingDivision instance.
REQ-014 rsp_id  output  IDW  index of the requester that issued the operation.
REQ-015 rsp_dz  output  1  divide-by-zero flag: latched divisor bits [30:0] all zero.

Function
REQ-016 The block SHALL instantiate exactly one FloatingDivision and drive its A/B only from internal operand registers op_a/op_b.
REQ-017 States: IDLE, WAIT, HOLD.
REQ-018 IDLE: grant = first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ; req_ready[grant]=1, all other bits 0.
REQ-019 req_ready SHALL be 0 in WAIT and HOLD, and 0 in IDLE when no req_valid bit is set.
REQ-020 Handshake occurs on a clock edge where req_valid[i] and req_ready[i] are both 1: op_a/op_b <- req_a/req_b slice i, id <- i, ptr <- (i+1) mod NREQ, cnt <- DIV_CYCLES-1, state -> WAIT.
REQ-021 WAIT: cnt decrements each cycle; on the edge where cnt=0: rsp_data <- divider result, rsp_dz <- (op_b[30:0]==0), state -> HOLD.
REQ-022 Latency: handshake at edge E0 gives rsp_valid=1 after edge E0+DIV_CYCLES.
REQ-023 HOLD: rsp_valid=1; rsp_data, rsp_id and rsp_dz SHALL be stable until the edge where rsp_ready=1, after which state -> IDLE and rsp_valid=0.
REQ-024 rsp_valid SHALL be 0 in IDLE and WAIT.
REQ-025 Throughput: at most one operation per DIV_CYCLES+2 cycles; no operation is overlapped.
REQ-026 A requester that drops req_valid before its grant SHALL lose nothing; the ptr moves only on a handshake.
REQ-027 Changes on req_a/req_b after the handshake SHALL NOT affect the in-flight result.
REQ-028 rsp_ready asserted outside HOLD SHALL be ignored.
REQ-029 ptr wraps from NREQ-1 to 0.
REQ-030 Requester fairness: with all req_valid held high, grants SHALL follow 0,1,...,NREQ-1,0,...

Reset
REQ-031 While rst_n=0: state=IDLE, ptr=0, cnt=0, op_a=op_b=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_dz=0.
REQ-032 Reset asserted in WAIT or HOLD SHALL discard the operation; after release no response for it is produced.
REQ-033 The first grant after reset release SHALL follow REQ-018 with ptr=0.

Verification
REQ-034 Single request: requester 0 sends A=0x40866666 (4.2), B=0x404CCCCD (3.2) -> rsp_valid 2 cycles after the handshake, rsp_data=0x3FA80000 (1.3125) within ±1 ulp, rsp_id=0, rsp_dz=0.
REQ-035 Sign handling: requester 2 sends A=0xC0CCCCCD (-6.4), B=0xBF000000 (-0.5) -> 0x414CCCCD (12.8) within ±1 ulp; with A=0x40CCCCCD (6.4) the response is 0xC14CCCCD (-12.8).
REQ-036 Round-robin: all 4 req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; each handshake is DIV_CYCLES+2 cycles after the previous one.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_valid and rsp_data are stable, all req_ready=0, and the next grant comes only after the rsp_ready handshake.
REQ-038 Zero cases: A=0x00000000, B=0x4034B4B5 -> rsp_data=0x00000000, rsp_dz=0; B=0x80000000 -> rsp_dz=1.
REQ-039 Reset in WAIT: pull rst_n low one cycle after a handshake -> all outputs 0 immediately; after release, no rsp_valid appears until a new request.
